// File: rtl/motor_ramp_pwm_if.sv
// Target handshake bundle for motor_ramp_pwm (decoder side = master).
// MOTOR_DIR_EN adds a per-channel direction bit captured alongside the duty.
interface motor_ramp_pwm_if #(
  parameter int N_CH   = 2,
  parameter int DUTY_W = 10
);
  logic [N_CH*DUTY_W-1:0] target_duty;
  logic                   target_valid;
  logic                   target_ready;
`ifdef MOTOR_DIR_EN
  logic [N_CH-1:0]        target_dir;

  modport master (output target_duty, target_valid, target_dir, input target_ready);
  modport slave  (input target_duty, target_valid, target_dir, output target_ready);
`else
  modport master (output target_duty, target_valid, input target_ready);
  modport slave  (input target_duty, target_valid, output target_ready);
`endif
endinterface

// File: rtl/motor_ramp_pwm.sv
// N-channel PWM with slew-limited duty ramping; duty/threshold only move at period boundaries.
// Optional MOTOR_DIR_EN: per-channel direction with ramp-down / hold / flip reversal.
module motor_ramp_pwm #(
  parameter int N_CH   = 2,
  parameter int DUTY_W = 10,
  parameter int PERIOD = 4000,
  parameter int STEP   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  motor_ramp_pwm_if.slave        tgt_if,
  input  logic                   brake_i,
  output logic [N_CH-1:0]        pwm_o,
  output logic [N_CH*DUTY_W-1:0] cur_duty_o,
  output logic                   ramp_busy_o
`ifdef MOTOR_DIR_EN
  , output logic [N_CH-1:0]      dir_o
`endif
);
  localparam int CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW  = DUTY_W + CW;
  localparam int DW1 = DUTY_W + 1;
  localparam logic [DW1-1:0] STEP_W = DW1'(STEP);

  typedef logic [DUTY_W-1:0] duty_t;

  // Only steps by STEP when the gap exceeds STEP, so the result never leaves range.
  function automatic duty_t step_to(duty_t c, duty_t g);
    logic [DW1-1:0] c1, g1;
    c1 = {1'b0, c};
    g1 = {1'b0, g};
    if (g1 >= c1) step_to = ((g1 - c1) <= STEP_W) ? g : duty_t'(c1 + STEP_W);
    else          step_to = ((c1 - g1) <= STEP_W) ? g : duty_t'(c1 - STEP_W);
  endfunction

  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        rdy_q, rdy_d, busy_q, busy_d;
  logic                        bnd, acc, load;
  logic [N_CH-1:0][DUTY_W-1:0] pend_q, pend_d, cur_pk;
  logic [N_CH-1:0]             pwm_pk, ch_busy;
`ifdef MOTOR_DIR_EN
  logic [N_CH-1:0]             pdir_q, pdir_d, dir_pk;
`endif

  assign bnd  = (cnt_q == CW'(PERIOD - 1));
  assign acc  = tgt_if.target_valid && rdy_q && !brake_i;
  // ready low <=> a pending value is waiting for the boundary
  assign load = bnd && !rdy_q && !brake_i;

  always_comb begin
    cnt_d  = bnd ? '0 : cnt_q + CW'(1);
    rdy_d  = rdy_q;
    pend_d = pend_q;
    busy_d = |ch_busy;
`ifdef MOTOR_DIR_EN
    pdir_d = pdir_q;
`endif
    if (brake_i) begin
      rdy_d  = 1'b1;
      pend_d = '0;
`ifdef MOTOR_DIR_EN
      pdir_d = '0;
`endif
    end else begin
      if (bnd) rdy_d = 1'b1;
      if (acc) begin
        rdy_d  = 1'b0;
        pend_d = tgt_if.target_duty;
`ifdef MOTOR_DIR_EN
        pdir_d = tgt_if.target_dir;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
      pend_q <= '0;
`ifdef MOTOR_DIR_EN
      pdir_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
`ifdef MOTOR_DIR_EN
      pdir_q <= pdir_d;
`endif
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    duty_t         tgt_q, tgt_d, cur_q, cur_d, goal;
    logic [TW-1:0] thr_q, thr_d, prod;
    logic          pwm_q, pwm_d;
`ifdef MOTOR_DIR_EN
    logic          tdir_q, tdir_d, dir_q, dir_d, hold_q, hold_d;
`endif

    always_comb begin
      tgt_d = load ? pend_q[i] : tgt_q;
      goal  = tgt_d;
      cur_d = cur_q;
`ifdef MOTOR_DIR_EN
      tdir_d = load ? pdir_q[i] : tdir_q;
      dir_d  = dir_q;
      hold_d = hold_q;
      // Reversal: head for 0, sit there one full period, flip and ramp out.
      if (bnd) begin
        if (tdir_d == dir_q) hold_d = 1'b0;
        else if (hold_q) begin
          dir_d  = tdir_d;
          hold_d = 1'b0;
        end else goal = '0;
      end
`endif
      if (bnd) cur_d = step_to(cur_q, goal);
`ifdef MOTOR_DIR_EN
      if (bnd && (tdir_d != dir_q) && !hold_q) hold_d = (cur_d == '0);
`endif
      prod  = TW'(cur_d) * TW'(PERIOD);
      thr_d = bnd ? (prod >> DUTY_W) : thr_q;
      pwm_d = (TW'(cnt_q) < thr_q);
      if (brake_i) begin
        tgt_d = '0;
        cur_d = '0;
        thr_d = '0;
        pwm_d = 1'b0;
`ifdef MOTOR_DIR_EN
        tdir_d = dir_q;
        dir_d  = dir_q;
        hold_d = 1'b0;
`endif
      end
    end

`ifdef MOTOR_DIR_EN
    assign ch_busy[i] = (cur_d != tgt_d) || (tdir_d != dir_d);
    assign dir_pk[i]  = dir_q;
`else
    assign ch_busy[i] = (cur_d != tgt_d);
`endif
    assign cur_pk[i] = cur_q;
    assign pwm_pk[i] = pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tgt_q <= '0;
        cur_q <= '0;
        thr_q <= '0;
        pwm_q <= 1'b0;
`ifdef MOTOR_DIR_EN
        tdir_q <= 1'b0;
        dir_q  <= 1'b0;
        hold_q <= 1'b0;
`endif
      end else begin
        tgt_q <= tgt_d;
        cur_q <= cur_d;
        thr_q <= thr_d;
        pwm_q <= pwm_d;
`ifdef MOTOR_DIR_EN
        tdir_q <= tdir_d;
        dir_q  <= dir_d;
        hold_q <= hold_d;
`endif
      end
    end
  end

  assign tgt_if.target_ready = rdy_q;
  assign pwm_o               = pwm_pk;
  assign cur_duty_o          = cur_pk;
  assign ramp_busy_o         = busy_q;
`ifdef MOTOR_DIR_EN
  assign dir_o               = dir_pk;
`endif
endmodule

// File: tb/tb_motor_ramp_pwm.sv
// Bench for motor_ramp_pwm: directed scenarios plus a randomized run against a cycle-level model.
module tb_motor_ramp_pwm;
  localparam int N_CH   = 2;
  localparam int DUTY_W = 10;
  localparam int PERIOD = 250;
  localparam int STEP   = 64;
  localparam int FS     = (1 << DUTY_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   brake = 1'b0;
  logic [N_CH-1:0]        pwm;
  logic [N_CH*DUTY_W-1:0] cur_duty;
  logic                   ramp_busy;

  motor_ramp_pwm_if #(.N_CH(N_CH), .DUTY_W(DUTY_W)) tif ();
`ifdef MOTOR_DIR_EN
  logic [N_CH-1:0] dir;
  assign tif.target_dir = '0;
`endif

  motor_ramp_pwm #(.N_CH(N_CH), .DUTY_W(DUTY_W), .PERIOD(PERIOD), .STEP(STEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tgt_if      (tif),
    .brake_i     (brake),
    .pwm_o       (pwm),
    .cur_duty_o  (cur_duty),
    .ramp_busy_o (ramp_busy)
`ifdef MOTOR_DIR_EN
    , .dir_o     (dir)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: state after each rising edge, in plain integers.
  int cyc;
  int m_cur [N_CH];
  int m_tgt [N_CH];
  int m_pend[N_CH];
  bit m_rdy, m_busy;
  bit [N_CH-1:0] m_pwm;

  function automatic int toward(int c, int t);
    if (t - c > STEP) return c + STEP;
    if (c - t > STEP) return c - STEP;
    return t;
  endfunction

  function automatic int cur_of(int i);
    return int'(cur_duty[i*DUTY_W +: DUTY_W]);
  endfunction

  task automatic model_reset();
    cyc = 0; m_rdy = 1'b1; m_busy = 1'b0; m_pwm = '0;
    for (int i = 0; i < N_CH; i++) begin m_cur[i] = 0; m_tgt[i] = 0; m_pend[i] = 0; end
  endtask

  task automatic model_step();
    bit acc;
    int cnt;
    acc = tif.target_valid && m_rdy && !brake;
    cnt = cyc % PERIOD;
    for (int i = 0; i < N_CH; i++)
      m_pwm[i] = !brake && (cnt < (m_cur[i] * PERIOD) / (1 << DUTY_W));
    if (brake) begin
      for (int i = 0; i < N_CH; i++) begin m_cur[i] = 0; m_tgt[i] = 0; m_pend[i] = 0; end
      m_rdy = 1'b1;
    end else begin
      if (cnt == PERIOD - 1) begin
        if (!m_rdy) for (int i = 0; i < N_CH; i++) m_tgt[i] = m_pend[i];
        m_rdy = 1'b1;
        for (int i = 0; i < N_CH; i++) m_cur[i] = toward(m_cur[i], m_tgt[i]);
      end
      if (acc) begin
        for (int i = 0; i < N_CH; i++) m_pend[i] = int'(tif.target_duty[i*DUTY_W +: DUTY_W]);
        m_rdy = 1'b0;
      end
    end
    m_busy = 1'b0;
    for (int i = 0; i < N_CH; i++) if (m_cur[i] != m_tgt[i]) m_busy = 1'b1;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; brake = 1'b0; tif.target_valid = 1'b0; tif.target_duty = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_target(int d0, int d1);
    tif.target_duty = {DUTY_W'(d1), DUTY_W'(d0)};
    tif.target_valid = 1'b1;
    tick();
    tif.target_valid = 1'b0;
  endtask

  task automatic wait_bnd();
    do tick(); while (cyc % PERIOD != 0);
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++; if (tif.target_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", tif.target_ready); else passed++;
    checks++; if (cur_duty !== '0) $display("FAIL rst_cur got %0h want 0", cur_duty); else passed++;
    checks++; if (pwm !== '0 || ramp_busy !== 1'b0) $display("FAIL rst_pwm_busy got %b/%b want 0/0", pwm, ramp_busy); else passed++;
    set_target(200, 0);
    wait_bnd(); wait_bnd();
    set_target(300, 0);
    repeat (9) tick();
    checks++; if (pwm[0] !== 1'b1) $display("FAIL pre_rst_pwm got %b want 1", pwm[0]); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm !== '0 || cur_duty !== '0 || tif.target_ready !== 1'b1 || ramp_busy !== 1'b0)
      $display("FAIL midrst got pwm=%b cur=%0h rdy=%b busy=%b want 0/0/1/0", pwm, cur_duty, tif.target_ready, ramp_busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tif.target_duty = {DUTY_W'(0), DUTY_W'(100)};
    tif.target_valid = 1'b1;
    n = 0;
    do begin tick(); tif.target_valid = 1'b0; n++; end while (cur_of(0) == 0 && n < 2*PERIOD);
    checks++; if (n != PERIOD || cur_of(0) != 64) $display("FAIL first_bnd got edge=%0d cur=%0d want %0d/64", n, cur_of(0), PERIOD); else passed++;
  endtask

  task automatic test_step();
    int e;
    do_reset();
    set_target(1000, 0);
    for (int b = 1; b <= 16; b++) begin
      wait_bnd();
      e = (64*b > 1000) ? 1000 : 64*b;
      checks++; if (cur_of(0) != e) $display("FAIL step_cur b=%0d got %0d want %0d", b, cur_of(0), e); else passed++;
      checks++; if (ramp_busy !== (b < 16)) $display("FAIL step_busy b=%0d got %b want %b", b, ramp_busy, (b < 16)); else passed++;
    end
  endtask

  task automatic test_duty();
    int hi, first, last;
    do_reset();
    set_target(512, 0);
    repeat (8) wait_bnd();
    checks++; if (cur_of(0) != 512) $display("FAIL duty_cur got %0d want 512", cur_of(0)); else passed++;
    hi = 0; first = -1; last = -1;
    for (int j = 1; j <= PERIOD; j++) begin
      tick();
      if (pwm[0]) begin hi++; if (first < 0) first = j; last = j; end
      if (pwm[1]) hi += 1000;
    end
    checks++; if (hi != 125) $display("FAIL duty_512_high got %0d want 125", hi); else passed++;
    checks++; if (first != 1 || last != 125) $display("FAIL duty_512_span got %0d..%0d want 1..125", first, last); else passed++;
    set_target(FS, 0);
    repeat (8) wait_bnd();
    hi = 0; first = -1;
    for (int j = 1; j <= PERIOD; j++) begin
      tick();
      if (pwm[0]) begin hi++; if (first < 0) first = j; end
    end
    checks++; if (hi != 249 || first != 1) $display("FAIL duty_fs got high=%0d first=%0d want 249/1", hi, first); else passed++;
  endtask

  task automatic test_handshake();
    int accs, lows;
    do_reset();
    accs = 0; lows = 0;
    tif.target_valid = 1'b1;
    for (int k = 0; k < 3*PERIOD; k++) begin
      if (tif.target_ready) accs++; else lows++;
      tif.target_duty = N_CH*DUTY_W'($urandom);
      tick();
    end
    tif.target_valid = 1'b0;
    checks++; if (accs != 3) $display("FAIL hs_accepts got %0d want 3", accs); else passed++;
    checks++; if (lows != 3*(PERIOD-1)) $display("FAIL hs_ready_low got %0d want %0d", lows, 3*(PERIOD-1)); else passed++;
    do_reset();
    while (cyc % PERIOD != PERIOD - 1) tick();
    set_target(500, 200);
    checks++; if (tif.target_ready !== 1'b0 || cur_duty !== '0) $display("FAIL hs_bnd_accept got rdy=%b cur=%0h want 0/0", tif.target_ready, cur_duty); else passed++;
    wait_bnd();
    checks++; if (cur_of(0) != 64 || cur_of(1) != 64) $display("FAIL hs_bnd_apply got %0d/%0d want 64/64", cur_of(0), cur_of(1)); else passed++;
    checks++; if (tif.target_ready !== 1'b1) $display("FAIL hs_ready_back got %b want 1", tif.target_ready); else passed++;
  endtask

  task automatic test_brake();
    int e;
    do_reset();
    set_target(700, 0);
    repeat (11) wait_bnd();
    checks++; if (cur_of(0) != 700) $display("FAIL brk_pre_cur got %0d want 700", cur_of(0)); else passed++;
    set_target(900, 0);
    repeat (39) tick();
    checks++; if (pwm[0] !== 1'b1) $display("FAIL brk_pre_pwm got %b want 1", pwm[0]); else passed++;
    brake = 1'b1;
    tif.target_duty = {DUTY_W'(0), DUTY_W'(555)};
    tif.target_valid = 1'b1;
    tick();
    brake = 1'b0;
    tif.target_valid = 1'b0;
    checks++;
    if (pwm !== '0 || cur_duty !== '0 || tif.target_ready !== 1'b1 || ramp_busy !== 1'b0)
      $display("FAIL brk_now got pwm=%b cur=%0h rdy=%b busy=%b want 0/0/1/0", pwm, cur_duty, tif.target_ready, ramp_busy);
    else passed++;
    repeat (5) tick();
    checks++; if (pwm !== '0) $display("FAIL brk_hold_pwm got %b want 0", pwm); else passed++;
    wait_bnd();
    checks++; if (cur_duty !== '0) $display("FAIL brk_pend_drop got %0h want 0", cur_duty); else passed++;
    set_target(300, 0);
    for (int b = 1; b <= 5; b++) begin
      wait_bnd();
      e = (64*b > 300) ? 300 : 64*b;
      checks++; if (cur_of(0) != e) $display("FAIL brk_ramp b=%0d got %0d want %0d", b, cur_of(0), e); else passed++;
    end
  endtask

  task automatic test_random();
    logic [N_CH*DUTY_W-1:0] ev;
    int fails;
    do_reset();
    fails = 0;
    for (int k = 0; k < 40*PERIOD && fails < 20; k++) begin
      tif.target_valid = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N_CH; i++) tif.target_duty[i*DUTY_W +: DUTY_W] = DUTY_W'($urandom_range(0, FS));
      brake = ($urandom_range(0, 699) == 0);
      tick();
      for (int i = 0; i < N_CH; i++) ev[i*DUTY_W +: DUTY_W] = DUTY_W'(m_cur[i]);
      checks++;
      if (cur_duty !== ev || pwm !== m_pwm || tif.target_ready !== m_rdy || ramp_busy !== m_busy) begin
        fails++;
        $display("FAIL rand cyc=%0d got cur=%0h pwm=%b rdy=%b busy=%b want cur=%0h pwm=%b rdy=%b busy=%b",
                 cyc, cur_duty, pwm, tif.target_ready, ramp_busy, ev, m_pwm, m_rdy, m_busy);
      end else passed++;
    end
    brake = 1'b0;
    tif.target_valid = 1'b0;
  endtask

  initial begin
    tif.target_valid = 1'b0;
    tif.target_duty  = '0;
    model_reset();
    test_reset();
    test_step();
    test_duty();
    test_handshake();
    test_brake();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired after %0d of %0d checks", passed, checks);
    $fatal(1, "timeout");
  end
endmodule
